// File: rtl/gpio_mmio.sv
// GPIO peripheral: per-pin direction, synchronised inputs, edge flags (W1C) with level IRQ,
// on the MCU memory bus with a registered one-wait-state handshake.
`timescale 1ns/1ps
module gpio_mmio #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             select_i,
  output logic             mem_ready_o,
  input  logic [3:0]       mem_wstrb_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic [31:0]      mem_rdata_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [3:0] REG_BSR = 4'd0;
  localparam logic [3:0] REG_OUT = 4'd1;
  localparam logic [3:0] REG_DIR = 4'd2;
  localparam logic [3:0] REG_IN  = 4'd3;
  localparam logic [3:0] REG_RIE = 4'd4;
  localparam logic [3:0] REG_FIE = 4'd5;
  localparam logic [3:0] REG_IFR = 4'd6;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] wd,
                                                  input logic [WIDTH-1:0] lanes);
    return (cur & ~lanes) | (wd & lanes);
  endfunction

  logic             ready_q;
  logic [31:0]      rdata_q;
  logic [WIDTH-1:0] out_q, dir_q, rie_q, fie_q, ifr_q, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic             access, wr_en;
  logic [3:0]       reg_idx;
  logic [15:0]      lanes16;
  logic [WIDTH-1:0] lanes, wdata_w, clr_bits, pin_s, rise, fall, w1c_mask;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign access   = select_i & ~ready_q;
  assign wr_en    = access & (|mem_wstrb_i);
  assign reg_idx  = mem_addr_i[5:2];
  assign lanes16  = {{8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
  assign lanes    = lanes16[WIDTH-1:0];
  assign wdata_w  = mem_wdata_i[WIDTH-1:0];
  assign clr_bits = mem_wdata_i[16 +: WIDTH];

  assign unused_bits = ^{mem_addr_i[31:6], mem_addr_i[1:0], mem_wstrb_i[3:2],
                         mem_wdata_i, lanes16};

  // Input synchroniser and edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pin_s;
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~prev_q;
  assign fall  = ~pin_s & prev_q;

  assign w1c_mask = (wr_en && reg_idx == REG_IFR) ? (wdata_w & lanes) : '0;

  always_comb begin
    rd_mux = '0;
    unique case (reg_idx)
      REG_BSR, REG_OUT: rd_mux = zext(out_q);
      REG_DIR:          rd_mux = zext(dir_q);
      REG_IN:           rd_mux = zext(pin_s);
      REG_RIE:          rd_mux = zext(rie_q);
      REG_FIE:          rd_mux = zext(fie_q);
      REG_IFR:          rd_mux = zext(ifr_q);
      default:          rd_mux = '0;
    endcase
  end

  // Bus handshake and register file
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      dir_q   <= '0;
      rie_q   <= '0;
      fie_q   <= '0;
      ifr_q   <= '0;
    end else begin
      ready_q <= access;
      rdata_q <= access ? rd_mux : '0;
      // A set event takes priority over a same-cycle clear.
      ifr_q   <= (ifr_q & ~w1c_mask) | (rise & rie_q) | (fall & fie_q);
      if (wr_en) begin
        unique case (reg_idx)
          REG_BSR: out_q <= (out_q | wdata_w) & ~clr_bits;
          REG_OUT: out_q <= lane_merge(out_q, wdata_w, lanes);
          REG_DIR: dir_q <= lane_merge(dir_q, wdata_w, lanes);
          REG_RIE: rie_q <= lane_merge(rie_q, wdata_w, lanes);
          REG_FIE: fie_q <= lane_merge(fie_q, wdata_w, lanes);
          default: ;
        endcase
      end
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign gpio_o      = out_q;
  assign gpio_oe_o   = dir_q;
  assign irq_o       = |ifr_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: table-driven register accesses on a 16-pin and an 8-pin
// instance, plus hand-written timing sequences for edges, W1C races, held select and reset.
`timescale 1ns/1ps
module tb_gpio_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] gpio_i = '0;

  logic        ready, irq, ready8, irq8;
  logic [31:0] rdata, rdata8;
  logic [15:0] gpio_o, gpio_oe;
  logic [7:0]  gpio_o8, gpio_oe8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpio_mmio #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .select_i(select), .mem_ready_o(ready),
    .mem_wstrb_i(wstrb), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rdata_o(rdata),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  gpio_mmio #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .select_i(select), .mem_ready_o(ready8),
    .mem_wstrb_i(wstrb), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rdata_o(rdata8),
    .gpio_i(gpio_i[7:0]), .gpio_o(gpio_o8), .gpio_oe_o(gpio_oe8), .irq_o(irq8)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
    logic [15:0] pins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [3:0] s, logic [31:0] wd,
                              logic [31:0] rd, logic [15:0] o, logic [15:0] oe,
                              logic [15:0] pins);
    vec_t v;
    v.wr = wr; v.addr = a; v.strb = s; v.wd = wd;
    v.exp_rd = rd; v.exp_out = o; v.exp_oe = oe; v.pins = pins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus(input bit wr, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] rd8);
    @(negedge clk);
    select = 1'b1; addr = a; wstrb = wr ? s : 4'h0; wdata = wd;
    @(posedge clk); #1;
    chk("ready_pulse", 32'(ready), 32'd1);
    rd = rdata; rd8 = rdata8;
    @(negedge clk);
    select = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
    chk("ready_low", 32'(ready), 32'd0);
    chk("rdata_idle", rdata, 32'd0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [31:0] d, d8;
    bus(1'b1, a, s, wd, d, d8);
  endtask

  task automatic rd_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d, d8;
    bus(1'b0, a, 4'h0, 32'h0, d, d8);
    chk(name, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d8;
    int pulses;

    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 32'(i * 4), 4'h0, 0, 32'h0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 32'h00, 4'hF, 32'h0000_00FF, 0, 16'h00FF, 16'h0000, 16'h0002));
    vecs.push_back(mk(1, 32'h00, 4'hF, 32'h000F_0030, 0, 16'h00F0, 16'h0000, 16'h0002));
    vecs.push_back(mk(0, 32'h00, 4'h0, 0, 32'h0000_00F0, 16'h00F0, 16'h0000, 16'h0002));
    vecs.push_back(mk(1, 32'h04, 4'h3, 32'h0000_1234, 0, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(mk(1, 32'h04, 4'h1, 32'h0000_AAAA, 0, 16'h12AA, 16'h0000, 16'h0002));
    vecs.push_back(mk(0, 32'h04, 4'h0, 0, 32'h0000_12AA, 16'h12AA, 16'h0000, 16'h0002));
    vecs.push_back(mk(1, 32'h08, 4'h3, 32'h0000_FFFF, 0, 16'h12AA, 16'hFFFF, 16'h0002));
    vecs.push_back(mk(0, 32'h08, 4'h0, 0, 32'h0000_FFFF, 16'h12AA, 16'hFFFF, 16'h0002));
    vecs.push_back(mk(1, 32'h08, 4'h2, 32'h0000_0000, 0, 16'h12AA, 16'h00FF, 16'h0002));
    vecs.push_back(mk(1, 32'h04, 4'hC, 32'hFFFF_5555, 0, 16'h12AA, 16'h00FF, 16'h0002));
    vecs.push_back(mk(1, 32'h00, 4'hF, 32'h0008_0008, 0, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(1, 32'h24, 4'hF, 32'hFFFF_FFFF, 0, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h24, 4'h0, 0, 32'h0000_0000, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h3C, 4'h0, 0, 32'h0000_0000, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h0C, 4'h0, 0, 32'h0000_0002, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(1, 32'h10, 4'h3, 32'h0000_0001, 0, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h10, 4'h0, 0, 32'h0000_0001, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(1, 32'h14, 4'h3, 32'h0000_0002, 0, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h14, 4'h0, 0, 32'h0000_0002, 16'h12A2, 16'h00FF, 16'h0002));
    vecs.push_back(mk(0, 32'h18, 4'h0, 0, 32'h0000_0000, 16'h12A2, 16'h00FF, 16'h0002));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gpio_o", 32'(gpio_o), 32'd0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      gpio_i = vecs[i].pins;
      bus(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wd, d, d8);
      if (!vecs[i].wr) begin
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
        chk($sformatf("vec%0d_rdata_w8", i), d8, vecs[i].exp_rd & 32'hFF);
      end
      chk($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
      chk($sformatf("vec%0d_gpio_o_w8", i), 32'(gpio_o8), 32'(vecs[i].exp_out[7:0]));
      chk($sformatf("vec%0d_gpio_oe_w8", i), 32'(gpio_oe8), 32'(vecs[i].exp_oe[7:0]));
    end

    // Edge flags: pin0 rises (RIE), pin1 falls (FIE); IRQ exactly 3 cycles later
    @(negedge clk); gpio_i = 16'h0001;
    @(posedge clk); #1; chk("irq_p1", 32'(irq), 32'd0);
    @(posedge clk); #1; chk("irq_p2", 32'(irq), 32'd0);
    @(posedge clk); #1; chk("irq_p3", 32'(irq), 32'd1);
    rd_reg("ifr_both", 32'h18, 32'h0000_0003);

    // W1C of IFR[0] on the same edge a new rising event on pin0 sets it
    @(negedge clk); gpio_i = 16'h0000;
    repeat (4) @(posedge clk);
    @(negedge clk); gpio_i = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); select = 1'b1; addr = 32'h18; wstrb = 4'h1; wdata = 32'h1;
    @(posedge clk); #1; chk("race_ready", 32'(ready), 32'd1);
    @(negedge clk); select = 1'b0; wstrb = 4'h0;
    rd_reg("ifr_race", 32'h18, 32'h0000_0003);
    wr_reg(32'h18, 4'h1, 32'h0000_0001);
    rd_reg("ifr_clr0", 32'h18, 32'h0000_0002);
    chk("irq_ifr1", 32'(irq), 32'd1);
    wr_reg(32'h18, 4'h1, 32'h0000_0000);
    rd_reg("ifr_w0", 32'h18, 32'h0000_0002);
    wr_reg(32'h18, 4'h2, 32'h0000_0002);
    rd_reg("ifr_lane", 32'h18, 32'h0000_0002);
    wr_reg(32'h18, 4'h1, 32'h0000_0002);
    rd_reg("ifr_clr1", 32'h18, 32'h0000_0000);
    chk("irq_clear", 32'(irq), 32'd0);

    // IN latency: access edge 2 cycles after pin change sees old value, 3 sees new
    @(negedge clk); gpio_i = 16'h0005;
    @(posedge clk);
    @(negedge clk); select = 1'b1; addr = 32'h0C;
    @(posedge clk); #1; chk("in_early", rdata, 32'h0000_0001);
    @(negedge clk); select = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); gpio_i = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); select = 1'b1; addr = 32'h0C;
    @(posedge clk); #1; chk("in_ontime", rdata, 32'h0000_0004);
    @(negedge clk); select = 1'b0;

    // Enabling RIE on an already-high pin raises nothing
    wr_reg(32'h10, 4'h3, 32'h0000_0005);
    rd_reg("rie_on_high", 32'h18, 32'h0000_0000);

    // Held select writing OUT: ready every other cycle, one commit per pulse
    pulses = 0;
    @(negedge clk); select = 1'b1; addr = 32'h04; wstrb = 4'h3; wdata = 32'h0100;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) pulses++;
      chk($sformatf("hold_ready%0d", k), 32'(ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("hold_out%0d", k), 32'(gpio_o), 32'h0100 + 32'(k & ~1));
      @(negedge clk);
      if (k < 5) wdata = 32'h0100 + 32'(k + 1);
      else begin select = 1'b0; wstrb = 4'h0; end
    end
    chk("hold_pulses", 32'(pulses), 32'd3);

    // Reset asserted mid-access
    @(negedge clk); select = 1'b1; addr = 32'h04; wstrb = 4'h3; wdata = 32'h5555;
    gpio_i = 16'h000D;
    @(posedge clk); #1;
    chk("mid_ready", 32'(ready), 32'd1);
    chk("mid_out", 32'(gpio_o), 32'h5555);
    #2; rst_n = 1'b0; wdata = 32'h7777;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_out", 32'(gpio_o), 32'd0);
    chk("arst_oe", 32'(gpio_oe), 32'd0);
    @(posedge clk); #1; chk("arst_nocommit", 32'(gpio_o), 32'd0);
    @(negedge clk); select = 1'b0; wstrb = 4'h0; rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_out", 32'(gpio_o), 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    rd_reg("post_rst_ifr", 32'h18, 32'h0000_0000);
    rd_reg("post_rst_in", 32'h0C, 32'h0000_000D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
